osr_ext: RTL and testbench
==========================

# osr_ext

Parametrised output shift register for the PIO state machine: the next generation of the fixed 32-bit OSR. It adds a configurable data width, a programmable autopull threshold, and a direct valid/ready pop interface to the TX FIFO with a stall request back to the instruction executor. It sits between the TX FIFO and the OUT/PULL datapath of one PIO state machine.

## Interface
- W, 32, shift register width in bits (power of two, 8..64)
- SW, $clog2(W), width of shift-amount and threshold fields (derived)
- CW, $clog2(W)+1, width of count outputs (derived)

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- penable  in  1  state-machine clock enable; low freezes all state
- restart  in  1  mark OSR empty; data retained
- stalled  in  1  executor stalled this cycle; freezes all state
- dir  in  1  0 = shift left (MSB first), 1 = shift right (LSB first)
- shift  in  SW  OUT bit count; 0 means W
- do_shift  in  1  OUT instruction shifting this cycle
- set  in  1  explicit PULL/MOV load of din
- din  in  W  explicit load data
- autopull_en  in  1  runtime autopull enable
- pull_thresh  in  SW  autopull threshold; 0 means W
- fifo_valid  in  1  TX FIFO has data
- fifo_data  in  W  TX FIFO head
- fifo_ready  out  1  pop TX FIFO this cycle
- dout  out  W  shifted-out bits, right-aligned, masked to n bits
- shift_count  out  CW  bits consumed since last load
- shift_count_lookahead  out  CW  shift_count after this cycle's shift
- stall_req  out  1  OUT must retry next cycle (autopull pending)
- empty  out  1  shift_count >= effective threshold

## Operation
- n = (shift==0) ? W : shift; thr = (pull_thresh==0) ? W : pull_thresh.
- Priority per edge: !reset_n > restart > (!penable || stalled: hold) > set > autopull refill > do_shift.
- Reset: shift_reg=0, count=W. restart: count=W, shift_reg unchanged.
- set: shift_reg<=din, count<=0; fifo_ready=0 even if a refill was eligible.
- Autopull refill: autopull_en && count>=thr && fifo_valid && !set → shift_reg<=fifo_data, count<=0, fifo_ready=1.
- do_shift with autopull_en && count>=thr: stall_req=1, no shift, count unchanged (apart from any refill in the same cycle). The executor retries.
- Otherwise do_shift: left → dout = top n bits of shift_reg, shift_reg<<=n. Right → dout = bottom n bits, shift_reg>>=n. Vacated bits are 0. count <= min(count+n, W), computed at CW+1 bits (no wrap at W+W).
- No do_shift: dout = shift_reg & mask(n).
- lookahead = do_shift && !stall_req ? min(count+n, W) : count.
- n=W shift: shift_reg becomes 0; dout = the full register.

## Timing
- dout, fifo_ready, stall_req, lookahead, empty are combinational from current state and inputs. shift_reg and count update on the next clk edge.
- Refill-to-OUT: a stalled OUT retries 1 cycle later with count=0. Best-case empty→resume penalty is 1 cycle.
- fifo_ready is asserted only when fifo_valid=1 and the load commits on that edge. It is never asserted while !penable, stalled, restart or reset are active.
- Reset values: fifo_ready=0, stall_req=0, shift_count=W, lookahead=W, empty=1, dout=0.

## Configuration
- OSR_AUTOPULL_EN defined: autopull refill and stall_req behave as described.
- Undefined: refill logic is removed; fifo_ready=0 and stall_req=0 constantly; autopull_en, pull_thresh, fifo_valid and fifo_data are ignored. empty still reports count>=thr.

## Structure
- osr_pkg: shift-direction constants SHIFT_LEFT=0 and SHIFT_RIGHT=1, plus a function returning the effective count (0→W) for a given width.
- Sub-module osr_shift_unit: combinational barrel shifter. It takes shift_reg, n and dir, and returns the shifted-out field and the new register value. It is parametrised by W.
- Top-level: count/priority/autopull control in osr_ext.

## Test plan
- W=32, reset_n=0 one cycle → shift_count=32, empty=1, dout=0, fifo_ready=0.
- set din=0xA5A5_00FF, dir=1, shift=8 → dout=0xFF, next shift_reg=0x00A5_A500, count=8.
- dir=0, set din=0xF000_0001, shift=4 → dout=0xF. Then shift=0 → dout=0x0000_0010, count saturates at 32 (not 36).
- autopull_en=1, thr=16, count=16, do_shift with fifo_valid=0 → stall_req=1, state held. Then fifo_valid=1, data=0x1234_5678 → fifo_ready=1, count=0. Retry shift=16 right → dout=0x5678.
- Refill eligible with set same cycle → din loaded, fifo_ready=0. stalled=1 with refill eligible → fifo_ready=0, no change.
- restart mid-word (count=12) → count=32, shift_reg unchanged. Build without OSR_AUTOPULL_EN → fifo_ready/stall_req stay 0 in all prior scenarios.

Source files
------------

// File: rtl/osr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osr_pkg
// Description : Shared constants and helpers for the PIO output shift
//               register (shift direction encoding, 0-means-full decode).
// Revision    : 1.0 - initial release
// ============================================================================
package osr_pkg;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // A field value of zero encodes the full register width.
  function automatic logic [7:0] eff_count(input logic [7:0] field,
                                           input logic [7:0] width);
    return (field == 8'd0) ? width : field;
  endfunction

endpackage
`default_nettype wire

// File: rtl/osr_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : osr_shift_unit
// Description : Combinational barrel shifter for the output shift register.
//               Produces the right-aligned shifted-out field, the register
//               value after the shift, and the register masked to n bits.
// Revision    : 1.0 - initial release
// ============================================================================
module osr_shift_unit
  import osr_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  shift_reg,
  input  logic [CW-1:0] n,
  input  logic          dir,
  output logic [W-1:0]  field,
  output logic [W-1:0]  masked,
  output logic [W-1:0]  next_reg
);

  // Double-width shifts let n == W work without an out-of-range shift.
  logic [2*W-1:0] w_left;
  logic [2*W-1:0] w_right;
  logic [2*W-1:0] w_mask_wide;
  logic           w_unused;

  assign w_left      = {{W{1'b0}}, shift_reg} << n;
  assign w_right     = {shift_reg, {W{1'b0}}} >> n;
  assign w_mask_wide = ~({(2*W){1'b1}} << n);
  assign masked      = shift_reg & w_mask_wide[W-1:0];
  assign w_unused    = ^{w_right[W-1:0], w_mask_wide[2*W-1:W]};

  // Select field and remaining bits according to shift direction.
  always_comb begin
    field    = '0;
    next_reg = '0;
    if (dir == SHIFT_LEFT) begin
      field    = w_left[2*W-1:W];
      next_reg = w_left[W-1:0];
    end else begin
      field    = masked;
      next_reg = w_right[2*W-1:W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/osr_ext.sv
`default_nettype none
// ============================================================================
// Module      : osr_ext
// Description : Parametrised PIO output shift register with programmable
//               autopull threshold, valid/ready TX FIFO pop and stall request.
//               Optional feature macro: OSR_AUTOPULL_EN (autopull refill and
//               stall request; without it both outputs are tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module osr_ext
  import osr_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = $clog2(W),
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          penable,
  input  logic          restart,
  input  logic          stalled,
  input  logic          dir,
  input  logic [SW-1:0] shift,
  input  logic          do_shift,
  input  logic          set,
  input  logic [W-1:0]  din,
  input  logic          autopull_en,
  input  logic [SW-1:0] pull_thresh,
  input  logic          fifo_valid,
  input  logic [W-1:0]  fifo_data,
  output logic          fifo_ready,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] shift_count,
  output logic [CW-1:0] shift_count_lookahead,
  output logic          stall_req,
  output logic          empty
);

  localparam logic [CW-1:0] c_FULL      = CW'(W);
  localparam logic [CW:0]   c_FULL_WIDE = (CW+1)'(W);

  logic [W-1:0]  r_shift_reg;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_n;
  logic [CW-1:0] w_thr;
  logic          w_active;
  logic          w_at_thr;
  logic          w_refill;
  logic          w_stall;
  logic          w_shift_go;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_sat;
  logic [W-1:0]  w_field;
  logic [W-1:0]  w_masked;
  logic [W-1:0]  w_next_reg;

  assign w_n   = CW'(eff_count(8'(shift), 8'(W)));
  assign w_thr = CW'(eff_count(8'(pull_thresh), 8'(W)));

  // State may only change when out of reset, not restarting, enabled and not stalled.
  assign w_active = reset_n && !restart && penable && !stalled;
  assign w_at_thr = (r_count >= w_thr);

`ifdef OSR_AUTOPULL_EN
  assign w_refill = w_active && autopull_en && w_at_thr && fifo_valid && !set;
  assign w_stall  = do_shift && autopull_en && w_at_thr;
`else
  logic w_unused;
  assign w_unused = ^{autopull_en, fifo_valid, fifo_data};
  assign w_refill = 1'b0;
  assign w_stall  = 1'b0;
`endif

  assign w_shift_go = do_shift && !w_stall;

  // Extra bit keeps count + n from wrapping before saturation at W.
  assign w_sum = {1'b0, r_count} + {1'b0, w_n};
  assign w_sat = (w_sum > c_FULL_WIDE) ? c_FULL : w_sum[CW-1:0];

  osr_shift_unit #(
    .W  (W),
    .CW (CW)
  ) u_shift (
    .shift_reg (r_shift_reg),
    .n         (w_n),
    .dir       (dir),
    .field     (w_field),
    .masked    (w_masked),
    .next_reg  (w_next_reg)
  );

  assign fifo_ready            = w_refill;
  assign stall_req             = w_stall;
  assign dout                  = w_shift_go ? w_field : w_masked;
  assign shift_count           = r_count;
  assign shift_count_lookahead = w_shift_go ? w_sat : r_count;
  assign empty                 = w_at_thr;

  // Register and count update in priority order: reset, restart, hold, load, refill, shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift_reg <= '0;
      r_count     <= c_FULL;
    end else if (restart) begin
      r_count <= c_FULL;
    end else if (!penable || stalled) begin
      r_count <= r_count;
    end else if (set) begin
      r_shift_reg <= din;
      r_count     <= '0;
    end else if (w_refill) begin
      r_shift_reg <= fifo_data;
      r_count     <= '0;
    end else if (w_shift_go) begin
      r_shift_reg <= w_next_reg;
      r_count     <= w_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osr_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_osr_ext
// Description : Scoreboard bench for osr_ext (W=32). Directed vectors push
//               hand-computed expectations; a negedge monitor pops and checks.
//               Expectations adapt to whether OSR_AUTOPULL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osr_ext;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int CW = 6;

`ifdef OSR_AUTOPULL_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, penable, restart, stalled, dir, do_shift, set;
  logic [SW-1:0] shift, pull_thresh;
  logic [W-1:0]  din, fifo_data;
  logic          autopull_en, fifo_valid;
  logic          fifo_ready, stall_req, empty;
  logic [W-1:0]  dout;
  logic [CW-1:0] shift_count, shift_count_lookahead;

  osr_ext #(.W(W)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .penable               (penable),
    .restart               (restart),
    .stalled               (stalled),
    .dir                   (dir),
    .shift                 (shift),
    .do_shift              (do_shift),
    .set                   (set),
    .din                   (din),
    .autopull_en           (autopull_en),
    .pull_thresh           (pull_thresh),
    .fifo_valid            (fifo_valid),
    .fifo_data             (fifo_data),
    .fifo_ready            (fifo_ready),
    .dout                  (dout),
    .shift_count           (shift_count),
    .shift_count_lookahead (shift_count_lookahead),
    .stall_req             (stall_req),
    .empty                 (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic [5:0]  cnt;
    logic [5:0]  la;
    logic        stall;
    logic        ready;
    logic        empty;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.nm, "dout",  dout, e.dout);
        cmp(e.nm, "count", 32'(shift_count), 32'(e.cnt));
        cmp(e.nm, "look",  32'(shift_count_lookahead), 32'(e.la));
        cmp(e.nm, "stall", 32'(stall_req), 32'(e.stall));
        cmp(e.nm, "ready", 32'(fifo_ready), 32'(e.ready));
        cmp(e.nm, "empty", 32'(empty), 32'(e.empty));
      end
    end
  end

  // Push the expectation for the inputs currently applied, then advance a cycle.
  task automatic vec(input string nm, input logic [31:0] d, input int c, input int l,
                     input logic st, input logic rd, input logic em);
    exp_t e;
    e.nm = nm; e.dout = d; e.cnt = 6'(c); e.la = 6'(l);
    e.stall = st; e.ready = rd; e.empty = em;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; penable = 1'b1; restart = 1'b0; stalled = 1'b0;
    dir = 1'b0; shift = '0; do_shift = 1'b0; set = 1'b0; din = '0;
    autopull_en = 1'b0; pull_thresh = '0; fifo_valid = 1'b0; fifo_data = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    vec("reset", 32'h0, 32, 32, 0, 0, 1);

    set = 1; din = 32'hA5A5_00FF; dir = 1; shift = 5'd8;
    vec("set_a5", 32'h0, 32, 32, 0, 0, 1);
    set = 0; do_shift = 1;
    vec("shr8", 32'h0000_00FF, 0, 8, 0, 0, 0);
    do_shift = 0; shift = 5'd0;
    vec("peek", 32'h00A5_A500, 8, 8, 0, 0, 0);

    set = 1; din = 32'hF000_0001; dir = 0; shift = 5'd4;
    vec("set_f0", 32'h0, 8, 8, 0, 0, 0);
    set = 0; do_shift = 1;
    vec("shl4", 32'h0000_000F, 0, 4, 0, 0, 0);
    shift = 5'd0;
    vec("shl32", 32'h0000_0010, 4, 32, 0, 0, 0);
    do_shift = 0;
    vec("sat", 32'h0, 32, 32, 0, 0, 1);

    set = 1; din = 32'hCAFE_BEEF; dir = 1; autopull_en = 1; pull_thresh = 5'd16;
    vec("set_b", 32'h0, 32, 32, 0, 0, 1);
    set = 0; do_shift = 1; shift = 5'd16;
    vec("shr16", 32'h0000_BEEF, 0, 16, 0, 0, 0);
    vec("stall", 32'h0000_CAFE, 16, AP ? 16 : 32, AP, 0, 1);
    fifo_valid = 1; fifo_data = 32'h1234_5678;
    vec("refill", AP ? 32'h0000_CAFE : 32'h0, AP ? 16 : 32, AP ? 16 : 32, AP, AP, 1);
    fifo_valid = 0;
    vec("retry", AP ? 32'h0000_5678 : 32'h0, AP ? 0 : 32, AP ? 16 : 32, 0, 0, !AP);

    do_shift = 0; shift = 5'd0; set = 1; din = 32'h0F0F_0F0F;
    fifo_valid = 1; fifo_data = 32'hDEAD_DEAD;
    vec("set_vs_refill", AP ? 32'h0000_1234 : 32'h0, AP ? 16 : 32, AP ? 16 : 32, 0, 0, 1);
    set = 0; fifo_valid = 0; do_shift = 1; shift = 5'd12;
    vec("shr12", 32'h0000_0F0F, 0, 12, 0, 0, 0);

    do_shift = 0; shift = 5'd0; pull_thresh = 5'd8; stalled = 1; fifo_valid = 1;
    vec("stalled_hold", 32'h0000_F0F0, 12, 12, 0, 0, 1);
    stalled = 0; restart = 1;
    vec("restart", 32'h0000_F0F0, 12, 12, 0, 0, 1);
    restart = 0; fifo_valid = 0; autopull_en = 0; pull_thresh = 5'd0;
    vec("after_restart", 32'h0000_F0F0, 32, 32, 0, 0, 1);

    penable = 0; set = 1; din = 32'h1111_1111;
    vec("penable_low", 32'h0000_F0F0, 32, 32, 0, 0, 1);
    penable = 1; set = 0;
    vec("hold_check", 32'h0000_F0F0, 32, 32, 0, 0, 1);

    chk_en = 1'b0;
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
